// File: rtl/uart_stream_if.sv
// Valid/ready word stream feeding the UART transmitter FIFO.
// A word transfers on every rising clk edge where s_valid && s_ready are both high.
// s_data must be stable whenever s_valid is high. s_ready may drop without waiting for s_valid.
interface uart_stream_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/uart_stream_tx.sv
// UART transmitter: FIFO-buffered valid/ready word stream serialised onto tx with
// programmable bit period, width, bit order, parity and stop bits; queued frames go out gap-free.
module uart_stream_tx #(
    parameter int CLK_DIV    = 10417,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_stream_if.slave                  s,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [2:0]                    state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          ODD_FLIP  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state;
    logic [BW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    logic                 push;
    logic                 pop;
    logic                 tick;
    logic                 stop_done;
    logic                 out_bit;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shifted;

    assign s.s_ready = (fifo_level != LW'(FIFO_DEPTH));
    assign push      = s.s_valid && s.s_ready;
    assign tick      = (baud_cnt == BAUD_MAX);
    assign stop_done = (state == S_STOP) && tick && (bit_cnt == STOP_LAST);
    // Pops happen only from IDLE or on the last stop edge, so the next start bit follows at once.
    assign pop       = (fifo_level != '0) && ((state == S_IDLE) || stop_done);
    assign head      = mem[rd_ptr];
    assign out_bit   = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];
    assign shifted   = (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], 1'b0}
                                        : {1'b0, shreg[DATA_BITS-1:1]};
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s.s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            baud_cnt <= (state == S_IDLE || tick) ? '0 : baud_cnt + 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg    <= head;
                        par_bit  <= (^head) ^ ODD_FLIP;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx      <= out_bit;
                        shreg   <= shifted;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx      <= out_bit;
                            shreg   <= shifted;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (stop_done) begin
                        if (pop) begin
                            shreg    <= head;
                            par_bit  <= (^head) ^ ODD_FLIP;
                            tx       <= 1'b0;
                            baud_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= S_START;
                        end else begin
                            tx    <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (tick) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: four configurations share one driver and one line monitor;
// frames captured from tx are compared against an expected-frame queue.
module tb_uart_stream_tx;
    localparam int DIV = 4;

    logic       clk;
    logic       rst_n;
    int         sel;
    logic       valid_drv;
    logic [7:0] data_drv;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_frames = 0;
    int run = 0;
    int last_run = 0;
    logic mon_active = 1'b0;
    logic [11:0] exp_q[$];

    uart_stream_if #(.DATA_BITS(8)) if0 ();
    uart_stream_if #(.DATA_BITS(8)) if1 ();
    uart_stream_if #(.DATA_BITS(7)) if2 ();
    uart_stream_if #(.DATA_BITS(7)) if3 ();

    assign if0.s_valid = valid_drv && (sel == 0);
    assign if1.s_valid = valid_drv && (sel == 1);
    assign if2.s_valid = valid_drv && (sel == 2);
    assign if3.s_valid = valid_drv && (sel == 3);
    assign if0.s_data  = data_drv;
    assign if1.s_data  = data_drv;
    assign if2.s_data  = data_drv[6:0];
    assign if3.s_data  = data_drv[6:0];

    logic       tx0, tx1, tx2, tx3;
    logic       busy0, busy1, busy2, busy3;
    logic [2:0] lvl0, lvl1, lvl2, lvl3;
    logic [2:0] st0, st1, st2, st3;

    uart_stream_tx #(.CLK_DIV(DIV)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(if0.slave), .tx(tx0), .busy(busy0),
        .fifo_level(lvl0), .state_dbg(st0));
    uart_stream_tx #(.CLK_DIV(DIV), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(if1.slave), .tx(tx1), .busy(busy1),
        .fifo_level(lvl1), .state_dbg(st1));
    uart_stream_tx #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .s(if2.slave), .tx(tx2), .busy(busy2),
        .fifo_level(lvl2), .state_dbg(st2));
    uart_stream_tx #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .s(if3.slave), .tx(tx3), .busy(busy3),
        .fifo_level(lvl3), .state_dbg(st3));

    logic       tx_mon, busy_mon, ready_mon;
    logic [2:0] level_mon, state_mon;

    always_comb begin
        tx_mon    = tx0;
        busy_mon  = busy0;
        ready_mon = if0.s_ready;
        level_mon = lvl0;
        state_mon = st0;
        case (sel)
            1: begin tx_mon = tx1; busy_mon = busy1; ready_mon = if1.s_ready; level_mon = lvl1; state_mon = st1; end
            2: begin tx_mon = tx2; busy_mon = busy2; ready_mon = if2.s_ready; level_mon = lvl2; state_mon = st2; end
            3: begin tx_mon = tx3; busy_mon = busy3; ready_mon = if3.s_ready; level_mon = lvl3; state_mon = st3; end
            default: ;
        endcase
    end

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_mon === 1'b1) begin
            run <= run + 1;
        end else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int frame_bits(input int s);
        return (s >= 2) ? 11 : 10;
    endfunction

    // Reference frame in line order, first bit at position frame_bits-1.
    function automatic logic [11:0] model_frame(input int s, input logic [7:0] d);
        logic [11:0] f;
        int nd;
        int idx;
        logic p;
        nd = (s >= 2) ? 7 : 8;
        f  = '0;
        p  = 1'b0;
        for (int i = 0; i < nd; i++) begin
            idx = (s == 1) ? i : nd - 1 - i;
            f   = {f[10:0], d[idx]};
            p   = p ^ d[i];
        end
        if (s >= 2) f = {f[10:0], (s == 3) ? ~p : p};
        f = {f[10:0], 1'b1};
        if (s >= 2) f = {f[10:0], 1'b1};
        return f;
    endfunction

    // Scoreboard side: capture each frame from the line and pop its expected value.
    initial begin : line_monitor
        int nb;
        logic [11:0] cap;
        logic [11:0] e;
        logic first, steady, aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_mon === 1'b0) begin
                mon_active = 1'b1;
                n_frames++;
                nb      = frame_bits(sel);
                cap     = '0;
                steady  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    if (b != 0) @(negedge clk);
                    first = tx_mon;
                    if (rst_n !== 1'b1) aborted = 1'b1;
                    for (int k = 1; k < DIV; k++) begin
                        @(negedge clk);
                        if (tx_mon !== first) steady = 1'b0;
                        if (rst_n !== 1'b1) aborted = 1'b1;
                    end
                    cap = {cap[10:0], first};
                end
                if (!aborted) begin
                    check("bit_hold", 32'(steady), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL frame_unexpected: got %03h expected none", cap);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame", 32'(cap), 32'(e));
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    // Driver: returns 1 time unit after the accepting edge.
    task automatic push_word(input logic [7:0] d, input logic [11:0] e);
        int t;
        logic r;
        t = 0;
        valid_drv = 1'b1;
        data_drv  = d;
        forever begin
            @(negedge clk);
            r = ready_mon;
            @(posedge clk);
            if (r) break;
            t++;
            if (t > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL push_timeout: got no accept expected accept within 500 cycles");
                break;
            end
        end
        exp_q.push_back(e);
        #1 valid_drv = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy_mon !== 1'b0 || level_mon != 0 || mon_active || exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 3000) begin
                n_vec++;
                n_err++;
                $display("FAIL idle_timeout: got busy=%0b level=%0d pending=%0d expected idle",
                         busy_mon, level_mon, exp_q.size());
                exp_q.delete();
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          s;
        logic [7:0]  data;
        logic [11:0] frame;
    } vec_t;

    vec_t vecs[8];

    initial begin : stimulus
        int   acc[6];
        int   k;
        int   t;
        logic r;
        int   snap;
        int   tx_low, busy_hi, lvl_nz;

        vecs[0] = '{0, 8'hA5, 12'b00_0101001011};
        vecs[1] = '{0, 8'h3C, 12'b00_0001111001};
        vecs[2] = '{1, 8'hA5, 12'b00_0101001011};
        vecs[3] = '{1, 8'h01, 12'b00_0100000001};
        vecs[4] = '{2, 8'h07, 12'b0_00000111111};
        vecs[5] = '{3, 8'h07, 12'b0_00000111011};
        vecs[6] = '{2, 8'h55, 12'b0_01010101011};
        vecs[7] = '{3, 8'h55, 12'b0_01010101111};

        sel       = 0;
        valid_drv = 1'b0;
        data_drv  = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx_mon), 32'd1);
        check("rst_busy", 32'(busy_mon), 32'd0);
        check("rst_level", 32'(level_mon), 32'd0);
        check("rst_ready", 32'(ready_mon), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_tx", 32'(tx_mon), 32'd1);
        check("post_rst_busy", 32'(busy_mon), 32'd0);
        check("post_rst_state", 32'(state_mon), 32'd0);

        // Single frames from the table, one configuration at a time.
        for (int i = 0; i < 8; i++) begin
            sel = vecs[i].s;
            push_word(vecs[i].data, vecs[i].frame);
            check("accept_level", 32'(level_mon), 32'd1);
            check("accept_tx", 32'(tx_mon), 32'd1);
            check("accept_busy", 32'(busy_mon), 32'd0);
            @(posedge clk);
            #1;
            check("start_tx", 32'(tx_mon), 32'd0);
            check("start_busy", 32'(busy_mon), 32'd1);
            check("start_level", 32'(level_mon), 32'd0);
            check("start_state", 32'(state_mon), 32'd1);
            wait_idle();
            check("busy_len", 32'(last_run), 32'(frame_bits(sel) * DIV));
        end

        // Random bursts of three queued words per configuration.
        for (int s = 0; s < 4; s++) begin
            sel = s;
            for (int j = 0; j < 3; j++) begin
                data_drv = 8'($urandom_range(0, 255));
                push_word(data_drv, model_frame(s, data_drv));
            end
            wait_idle();
            check("burst_busy_len", 32'(last_run), 32'(3 * frame_bits(s) * DIV));
        end

        // Backpressure: six words held valid against a depth-4 FIFO.
        sel = 0;
        valid_drv = 1'b1;
        data_drv  = 8'h01;
        k = 0;
        t = 0;
        while (k < 6 && t < 500) begin
            @(negedge clk);
            r = ready_mon;
            @(posedge clk);
            #1;
            if (r) begin
                acc[k] = cyc;
                exp_q.push_back(model_frame(0, data_drv));
                k++;
                if (k == 5) begin
                    check("bp_full_ready", 32'(ready_mon), 32'd0);
                    check("bp_full_level", 32'(level_mon), 32'd4);
                end
                data_drv = data_drv + 8'd1;
            end
            t++;
        end
        valid_drv = 1'b0;
        check("bp_accepted", 32'(k), 32'd6);
        if (k == 6) begin
            for (int i = 1; i < 5; i++) check("bp_consecutive", 32'(acc[i] - acc[0]), 32'(i));
            check("bp_word6_edge", 32'(acc[5] - acc[0]), 32'd42);
        end
        wait_idle();
        check("bp_busy_len", 32'(last_run), 32'd240);

        // Push landing on the final stop edge of a frame with the FIFO empty.
        push_word(8'h3C, model_frame(0, 8'h3C));
        repeat (40) @(posedge clk);
        #1;
        valid_drv = 1'b1;
        data_drv  = 8'hC3;
        @(posedge clk);
        exp_q.push_back(model_frame(0, 8'hC3));
        #1;
        valid_drv = 1'b0;
        check("stopedge_busy", 32'(busy_mon), 32'd0);
        check("stopedge_tx", 32'(tx_mon), 32'd1);
        check("stopedge_level", 32'(level_mon), 32'd1);
        @(posedge clk);
        #1;
        check("stopedge_start_tx", 32'(tx_mon), 32'd0);
        check("stopedge_start_busy", 32'(busy_mon), 32'd1);
        wait_idle();
        check("stopedge_busy_len", 32'(last_run), 32'd40);

        // Reset during data bit 3 with two words still queued.
        push_word(8'h11, model_frame(0, 8'h11));
        push_word(8'h22, model_frame(0, 8'h22));
        push_word(8'h33, model_frame(0, 8'h33));
        check("rstmid_level", 32'(level_mon), 32'd2);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rstmid_tx", 32'(tx_mon), 32'd1);
        check("rstmid_busy", 32'(busy_mon), 32'd0);
        check("rstmid_level0", 32'(level_mon), 32'd0);
        snap = n_frames;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tx_low  = 0;
        busy_hi = 0;
        lvl_nz  = 0;
        repeat (80) begin
            @(negedge clk);
            if (tx_mon !== 1'b1) tx_low++;
            if (busy_mon !== 1'b0) busy_hi++;
            if (level_mon != 0) lvl_nz++;
        end
        check("rstmid_tx_quiet", 32'(tx_low), 32'd0);
        check("rstmid_busy_quiet", 32'(busy_hi), 32'd0);
        check("rstmid_level_quiet", 32'(lvl_nz), 32'd0);
        check("rstmid_no_frames", 32'(n_frames - snap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_stream_tx.md
# uart_stream_tx

Parametrised UART transmitter with a valid/ready input stream and an internal FIFO. It serialises words onto a single `tx` line with a programmable bit period, word width, bit order, parity and stop-bit count. Queued words go out back-to-back with no idle gap. It sits between a streaming data source (PS/AXI-stream bridge or on-chip logic) and the board UART pin, and replaces the fixed 8N1 free-running transmitter.

## Interface
Parameters:
- `CLK_DIV`, default 10417: clock cycles per bit. 100 MHz / 9600 baud. Must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame. Legal values 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: 1 or 2.
- `MSB_FIRST`, default 1: 1 sends bit `DATA_BITS-1` first; 0 sends bit 0 first.
- `FIFO_DEPTH`, default 4: FIFO entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1: single clock. Everything is on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `s_data`  in  DATA_BITS: word to transmit.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: FIFO can accept a word. Combinational, equal to `fifo_level != FIFO_DEPTH`.
- `tx`  out  1: serial line, registered. Idles high.
- `busy`  out  1: a frame is in progress (state ≠ IDLE). Registered.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1: number of queued words. Does not include the word being serialised.

## Operation
- **Push.** A word is accepted on an edge where `s_valid && s_ready`. Accepted words are stored in FIFO order. When `s_ready` = 0 the input is ignored; a full FIFO is never overwritten.
- **Frame format.** Start bit (0), then `DATA_BITS` data bits in the configured order, then a parity bit if `PARITY` ≠ 0, then `STOP_BITS` stop bits (1).
- **Parity.** Odd parity makes the total count of ones in data + parity odd. Even parity makes it even. Parity is computed from the popped word at load time.
- **State machine:** IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, drive `tx` = 0 and go to START. Otherwise hold `tx` = 1.
  - START: hold for one bit period, then drive the first data bit and go to DATA.
  - DATA: shift one bit per bit period. After the last data bit, go to PARITY if enabled, otherwise STOP.
  - PARITY: one bit period.
  - STOP: `STOP_BITS` bit periods with `tx` = 1. At the end, if the FIFO is non-empty, pop and go directly to START with `tx` = 0 on the same edge (zero gap). Otherwise go to IDLE.
- **Baud counter.** Width $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and wraps. A state or bit advances on the edge where the count is CLK_DIV-1. The counter is reset to 0 on every frame load.
- **Bit counter** tracks data bits sent and stop bits sent. It is cleared on entry to each field.
- **Simultaneous push and pop** (FIFO not full): both take effect and `fifo_level` is unchanged. When the FIFO is full, `s_ready` = 0, so no push can coincide with a pop.
- **Pop from empty** cannot occur; a pop is only issued when `fifo_level` ≠ 0.

## Timing
- **Reset values:** `tx` = 1, `busy` = 0, `fifo_level` = 0, `s_ready` = 1, state IDLE, both counters 0.
- **Reset asserted mid-frame:** `tx` returns to 1 asynchronously. The frame is abandoned and the FIFO is flushed.
- **Push to start bit:**
  - Word accepted on edge E0 with the FIFO empty and IDLE: the pop occurs on E1. `tx` falls and `busy` rises after E1. `fifo_level` is 1 after E0 and 0 after E1.
  - In-flight edge case: if E0 lands on the final STOP edge of the preceding frame, the start bit follows at E1 (one-edge gap). This is the only allowed gap.
- **Bit duration:** every bit lasts exactly `CLK_DIV` cycles.
- **Frame duration:** `CLK_DIV` × (1 + `DATA_BITS` + (`PARITY` ≠ 0) + `STOP_BITS`) cycles.
- **`busy` falls** on the edge ending the last stop bit, and only when the FIFO is empty.

## Test plan
All scenarios use `CLK_DIV` = 4.
1. **8N1, MSB first.** Defaults, push 0xA5. `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. Start bit falls 1 cycle after acceptance. `busy` high for exactly 40 cycles.
2. **LSB first.** `MSB_FIRST` = 0, push 0xA5. Data bits are 1,0,1,0,0,1,0,1.
3. **Parity and stop bits.** `DATA_BITS` = 7, `STOP_BITS` = 2.
   - `PARITY` = 2, push 0x07: parity bit = 1.
   - `PARITY` = 1, same word: parity bit = 0.
   - Both frames are 44 cycles long.
4. **Backpressure.** `FIFO_DEPTH` = 4, hold `s_valid` for 6 words 0x01–0x06.
   - Words 1–5 are accepted in 5 consecutive cycles, then `s_ready` = 0.
   - Word 6 is accepted on the edge after the second pop.
   - All 6 frames are emitted back-to-back with zero idle cycles, in order.
5. **Reset mid-frame.** Assert `rst_n` = 0 during data bit 3 with 2 words queued. `tx` = 1 immediately. After release, `fifo_level` = 0, `busy` = 0, and nothing is transmitted.
6. **Push at stop edge.** Push a word on the final STOP edge of a frame with the FIFO empty. The next start bit begins exactly 1 cycle later.
